// File: rtl/fifo_feed_ctrl.sv
// Load/feed sequencer for one edge's bank of DIM preload delay FIFOs:
// preloads one row per FIFO, then shifts the bank for 2*DIM-1 feed cycles.
module fifo_feed_ctrl #(
  parameter int unsigned DIM  = 8,
  parameter int unsigned BITS = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        hold,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DIM*BITS-1:0]         in_data,
  output logic [DIM*BITS-1:0]         fifo_d,
  output logic [DIM-1:0]              fifo_wr,
  output logic                        fifo_en,
  output logic                        feed_valid,
  output logic [$clog2(2*DIM)-1:0]    feed_idx,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned RW = $clog2(DIM);
  localparam int unsigned SW = $clog2(2*DIM);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t        state;
  logic [RW-1:0] row_cnt;
  logic [SW-1:0] shift_cnt;
  logic          accept;
  logic          feed;
  logic          last_row;
  logic          last_feed;

  // Handshake and strobes react in the same cycle; abort masks all of them.
  assign in_ready   = (state == LOAD) && !abort;
  assign accept     = in_ready && in_valid;
  assign fifo_wr    = accept ? (DIM'(1) << row_cnt) : '0;
  assign fifo_d     = in_data;
  assign feed       = (state == SHIFT) && !hold && !abort;
  assign fifo_en    = feed;
  assign feed_valid = feed;
  assign feed_idx   = shift_cnt;
  assign last_row   = (row_cnt == RW'(DIM - 1));
  assign last_feed  = (shift_cnt == SW'(2*DIM - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      row_cnt   <= '0;
      shift_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort) begin
      state     <= IDLE;
      row_cnt   <= '0;
      shift_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD;
            row_cnt   <= '0;
            shift_cnt <= '0;
            busy      <= 1'b1;
          end
        end
        LOAD: begin
          if (accept) begin
            if (last_row) begin
              state   <= SHIFT;
              row_cnt <= '0;
            end else begin
              row_cnt <= row_cnt + RW'(1);
            end
          end
        end
        SHIFT: begin
          // Counter parks on the last index instead of wrapping.
          if (!hold) begin
            if (last_feed) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              shift_cnt <= shift_cnt + SW'(1);
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          shift_cnt <= '0;
          busy      <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_feed_ctrl.sv
// Randomized and directed bench for fifo_feed_ctrl against a phase-count model.
module tb_fifo_feed_ctrl;
  localparam int DIM  = 4;
  localparam int BITS = 8;
  localparam int NFEED = 2*DIM - 1;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0, abort = 1'b0, hold = 1'b0, in_valid = 1'b0;
  logic                  in_ready;
  logic [DIM*BITS-1:0]   in_data = '0;
  logic [DIM*BITS-1:0]   fifo_d;
  logic [DIM-1:0]        fifo_wr;
  logic                  fifo_en, feed_valid, busy, done;
  logic [$clog2(2*DIM)-1:0] feed_idx;

  fifo_feed_ctrl #(.DIM(DIM), .BITS(BITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .hold(hold),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .fifo_d(fifo_d), .fifo_wr(fifo_wr), .fifo_en(fifo_en),
    .feed_valid(feed_valid), .feed_idx(feed_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a sequence is just "how many rows accepted" and "how many feeds done".
  bit m_active = 0;
  int m_rows = 0;
  int m_feeds = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_rows = 0; m_feeds = 0;
    end else if (abort) begin
      m_active = 0; m_rows = 0; m_feeds = 0;
    end else if (!m_active) begin
      if (start) begin m_active = 1; m_rows = 0; m_feeds = 0; end
    end else if (m_rows < DIM) begin
      if (in_valid) m_rows++;
    end else if (m_feeds < NFEED) begin
      if (!hold) m_feeds++;
    end else begin
      m_active = 0;
    end
  end

  // Monitor counters used by directed literal checks.
  int n_en = 0, n_wr = 0, n_done = 0, cyc = 0, done_at = 0;
  logic [15:0] wr_hist = '0;
  logic prev_done = 1'b0;

  task automatic clr_mon();
    n_en = 0; n_wr = 0; n_done = 0; cyc = 0; done_at = 0; wr_hist = '0;
  endtask

  always @(negedge clk) begin
    bit loading, shifting, fin, e_ready, e_acc, e_en;
    logic [DIM-1:0] e_wr;
    loading  = m_active && m_rows < DIM;
    shifting = m_active && m_rows == DIM && m_feeds < NFEED;
    fin      = m_active && m_rows == DIM && m_feeds == NFEED;
    e_ready  = loading && !abort;
    e_acc    = e_ready && in_valid;
    e_wr     = e_acc ? DIM'(1 << m_rows) : '0;
    e_en     = shifting && !hold && !abort;
    chk("in_ready", 32'(in_ready), 32'(e_ready));
    chk("fifo_wr", 32'(fifo_wr), 32'(e_wr));
    chk("fifo_en", 32'(fifo_en), 32'(e_en));
    chk("feed_valid", 32'(feed_valid), 32'(e_en));
    chk("busy", 32'(busy), 32'(m_active));
    chk("done", 32'(done), 32'(fin));
    if (shifting) chk("feed_idx", 32'(feed_idx), 32'(m_feeds));
    if (e_acc) chk("fifo_d", fifo_d, in_data);
    chk("inv_onehot_wr", 32'($onehot0(fifo_wr)), 32'd1);
    chk("inv_wr_en_excl", 32'((|fifo_wr) & fifo_en), 32'd0);
    chk("inv_done_twice", 32'(prev_done & done), 32'd0);
    prev_done = done;
    cyc++;
    if (fifo_en) n_en++;
    if (|fifo_wr) begin n_wr++; wr_hist = {wr_hist[11:0], fifo_wr}; end
    if (done) begin n_done++; if (done_at == 0) done_at = cyc; end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic kick();
    start = 1'b1; clr_mon(); step(); start = 1'b0;
  endtask

  task automatic load_rows(input int n, input int bubble_before, input int bubble_len, input bit start_busy);
    for (int r = 0; r < n; r++) begin
      if (r == bubble_before) begin
        in_valid = 1'b0;
        repeat (bubble_len) step();
      end
      in_valid = 1'b1;
      start = start_busy;
      for (int j = 0; j < DIM; j++) in_data[j*BITS +: BITS] = BITS'(r*DIM + j + 1);
      step();
    end
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_wr"}, 32'(fifo_wr), 0);
    chk({tag, "_en"}, 32'(fifo_en), 0);
    chk({tag, "_ready"}, 32'(in_ready), 0);
    chk({tag, "_fv"}, 32'(feed_valid), 0);
    chk({tag, "_idx"}, 32'(feed_idx), 0);
  endtask

  // Runs the SHIFT phase; optional hold, abort, start pulse or reset at given feed indices.
  task automatic run_feed(input int hold_at, input int hold_len, input int abort_at,
                          input int start_at, input int rst_at);
    int  hl;
    bit  used, sh, ended;
    hl = 0; used = 0; ended = 0;
    for (int i = 0; i < 60 && !ended; i++) begin
      sh = busy && !in_ready && !done;
      hold = 1'b0; abort = 1'b0; start = 1'b0;
      if (hl > 0) begin
        hold = 1'b1; hl--;
      end else if (!used && sh && int'(feed_idx) == hold_at) begin
        hold = 1'b1; hl = hold_len - 1; used = 1;
      end
      if (sh && int'(feed_idx) == start_at) start = 1'b1;
      if (sh && int'(feed_idx) == abort_at) begin
        abort = 1'b1; step(); abort = 1'b0;
        chk("abort_busy_low", 32'(busy), 0);
        step();
        chk("abort_no_done", 32'(n_done), 0);
        ended = 1;
      end else if (sh && int'(feed_idx) == rst_at) begin
        rst_n = 1'b0; #1;
        check_zero_outputs("rst_mid_shift");
        step(); rst_n = 1'b1; step();
        chk("rst_no_done", 32'(n_done), 0);
        ended = 1;
      end else begin
        step();
        if (done) begin
          hold = 1'b0; start = 1'b0;
          step();
          ended = 1;
        end
      end
    end
    hold = 1'b0; start = 1'b0; abort = 1'b0;
    if (!ended) chk("feed_timeout", 0, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst_n = 1'b1;
    step();

    // Basic sequence
    kick(); load_rows(DIM, -1, 0, 0); run_feed(-1, 0, -1, -1, -1);
    chk("basic_wr_order", 32'(wr_hist), 32'h1248);
    chk("basic_n_en", n_en, NFEED);
    chk("basic_done_at", done_at, 13);
    chk("basic_n_done", n_done, 1);
    chk("basic_busy_after", 32'(busy), 0);

    // Input bubbles between rows 1 and 2
    step();
    kick(); load_rows(DIM, 2, 2, 0); run_feed(-1, 0, -1, -1, -1);
    chk("bubble_n_wr", n_wr, DIM);
    chk("bubble_wr_order", 32'(wr_hist), 32'h1248);
    chk("bubble_done_at", done_at, 15);

    // Hold at feed_idx 3 for 3 cycles
    step();
    kick(); load_rows(DIM, -1, 0, 0); run_feed(3, 3, -1, -1, -1);
    chk("hold_n_en", n_en, NFEED);
    chk("hold_done_at", done_at, 16);

    // Abort during LOAD after 2 rows, then a fresh start
    step();
    kick(); load_rows(2, -1, 0, 0);
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort_load_busy", 32'(busy), 0);
    step(); step();
    chk("abort_load_no_done", n_done, 0);
    kick(); load_rows(DIM, -1, 0, 0); run_feed(-1, 0, -1, -1, -1);
    chk("restart_wr_order", 32'(wr_hist), 32'h1248);
    chk("restart_n_en", n_en, NFEED);

    // Abort at feed_idx 5
    step();
    kick(); load_rows(DIM, -1, 0, 0); run_feed(-1, 0, 5, -1, -1);
    chk("abort_feed_n_en", n_en, 5);

    // Start pulses while busy, then reset mid-SHIFT at feed_idx 2
    step();
    kick(); load_rows(DIM, -1, 0, 1); run_feed(-1, 0, -1, 1, -1);
    chk("startbusy_n_en", n_en, NFEED);
    chk("startbusy_done_at", done_at, 13);
    step();
    kick(); load_rows(DIM, -1, 0, 0); run_feed(-1, 0, -1, -1, 2);

    // Random traffic
    clr_mon();
    for (int i = 0; i < 3000; i++) begin
      start    = ($urandom % 8) == 0;
      abort    = ($urandom % 60) == 0;
      in_valid = ($urandom % 3) != 0;
      hold     = ($urandom % 4) == 0;
      in_data  = {$urandom, $urandom};
      step();
    end
    start = 0; abort = 0; in_valid = 0; hold = 0;
    step();
    chk("rand_some_done", 32'(n_done > 0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
